// File: rtl/host_bridge_pkg.sv
// Shared types and constants for the host register bridge.
package host_bridge_pkg;

    typedef enum logic [1:0] {
        OP_PING   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_READ   = 2'd2,
        OP_LAUNCH = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic [31:0] PING_SIG = 32'hDEADBEEF;

endpackage

// File: rtl/host_reg_bank.sv
// One register bank with a host write port and an accelerator write port.
// The host port wins when both target the same word in the same cycle.
module host_reg_bank #(
    parameter int DATA_W = 32,
    parameter int REGS   = 4,
    localparam int AW    = (REGS > 1) ? $clog2(REGS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         host_we,
    input  logic [AW-1:0]                host_addr,
    input  logic [DATA_W-1:0]            host_data,
    input  logic                         acc_we,
    input  logic [AW-1:0]                acc_addr,
    input  logic [DATA_W-1:0]            acc_data,
    output logic [REGS-1:0][DATA_W-1:0]  words
);

    logic [REGS-1:0][DATA_W-1:0] words_q;
    logic [REGS-1:0][DATA_W-1:0] words_d;
    logic                        acc_addr_ok;

    assign acc_addr_ok = {1'b0, acc_addr} < (AW + 1)'(REGS);

    always_comb begin
        words_d = words_q;
        if (acc_we && acc_addr_ok) begin
            words_d[acc_addr] = acc_data;
        end
        if (host_we) begin
            words_d[host_addr] = host_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            words_q <= '0;
        end else begin
            words_q <= words_d;
        end
    end

    assign words = words_q;

endmodule

// File: rtl/host_reg_bridge.sv
// Host command bridge: PING/WRITE/READ/LAUNCH over valid/ready channels into
// the accelerator operand/result banks.
module host_reg_bridge
    import host_bridge_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int NUM_BANKS     = 3,
    parameter int REGS_PER_BANK = 4,
    parameter int ID_W          = 32,
    parameter int ADDR_W        = 32,
    localparam int BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int REG_AW       = (REGS_PER_BANK > 1) ? $clog2(REGS_PER_BANK) : 1
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        req_valid,
    output logic                                        req_ready,
    input  logic [1:0]                                  req_opcode,
    input  logic [ID_W-1:0]                             req_id,
    input  logic [ADDR_W-1:0]                           req_addr,
    input  logic [DATA_W-1:0]                           req_data,
    output logic                                        resp_valid,
    input  logic                                        resp_ready,
    output logic [DATA_W-1:0]                           resp_data,
    output logic                                        resp_err,
    output logic [NUM_BANKS*REGS_PER_BANK*DATA_W-1:0]   acc_regs,
    input  logic                                        acc_wr_en,
    input  logic [BANK_W-1:0]                           acc_wr_bank,
    input  logic [REG_AW-1:0]                           acc_wr_addr,
    input  logic [DATA_W-1:0]                           acc_wr_data,
    output logic                                        acc_start,
    input  logic                                        acc_done
);

    state_e              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_err_q, resp_err_d;
    logic                acc_start_q, acc_start_d;

    logic [NUM_BANKS-1:0][REGS_PER_BANK-1:0][DATA_W-1:0] regs_all;

    opcode_e             op;
    logic                accept;
    logic                hit;
    logic                host_we;
    logic                acc_bank_ok;
    logic [BANK_W-1:0]   bank_sel;
    logic [REG_AW-1:0]   word_sel;
    logic [DATA_W-1:0]   rd_word;

    // Range checks use the full id/addr width so large values never alias a real word.
    assign hit         = (req_id < ID_W'(NUM_BANKS)) && (req_addr < ADDR_W'(REGS_PER_BANK));
    assign bank_sel    = req_id[BANK_W-1:0];
    assign word_sel    = req_addr[REG_AW-1:0];
    assign op          = opcode_e'(req_opcode);
    assign accept      = req_valid && req_ready_q;
    assign host_we     = accept && (op == OP_WRITE) && hit;
    assign acc_bank_ok = {1'b0, acc_wr_bank} < (BANK_W + 1)'(NUM_BANKS);
    assign rd_word     = hit ? regs_all[bank_sel][word_sel] : '0;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        host_reg_bank #(
            .DATA_W (DATA_W),
            .REGS   (REGS_PER_BANK)
        ) u_bank (
            .clock     (clock),
            .reset     (reset),
            .host_we   (host_we && (bank_sel == BANK_W'(b))),
            .host_addr (word_sel),
            .host_data (req_data),
            .acc_we    (acc_wr_en && acc_bank_ok && (acc_wr_bank == BANK_W'(b))),
            .acc_addr  (acc_wr_addr),
            .acc_data  (acc_wr_data),
            .words     (regs_all[b])
        );
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        acc_start_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_ready_d = 1'b0;
                    resp_data_d = '0;
                    resp_err_d  = 1'b0;
                    if (op == OP_LAUNCH) begin
                        state_d     = S_START;
                        acc_start_d = 1'b1;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        unique case (op)
                            OP_PING:  resp_data_d = DATA_W'(PING_SIG);
                            OP_READ:  begin
                                resp_data_d = rd_word;
                                resp_err_d  = !hit;
                            end
                            default:  resp_err_d = !hit;
                        endcase
                    end
                end
            end
            S_START, S_WAIT: begin
                // A completion pulse already present in the START cycle counts.
                if (acc_done) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            acc_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            acc_start_q  <= acc_start_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign acc_start  = acc_start_q;
    assign acc_regs   = regs_all;

endmodule

// File: tb/tb_host_reg_bridge.sv
// Directed bench for host_reg_bridge with a response scoreboard and a bank model.
module tb_host_reg_bridge;

    localparam int DATA_W = 32;
    localparam int NB     = 3;
    localparam int NR     = 4;
    localparam int FLAT_W = NB * NR * DATA_W;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_opcode = 2'd0;
    logic [31:0]       req_id = '0;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_data = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic [FLAT_W-1:0] acc_regs;
    logic              acc_wr_en = 1'b0;
    logic [1:0]        acc_wr_bank = '0;
    logic [1:0]        acc_wr_addr = '0;
    logic [31:0]       acc_wr_data = '0;
    logic              acc_start;
    logic              acc_done = 1'b0;

    host_reg_bridge dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_id      (req_id),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .acc_regs    (acc_regs),
        .acc_wr_en   (acc_wr_en),
        .acc_wr_bank (acc_wr_bank),
        .acc_wr_addr (acc_wr_addr),
        .acc_wr_data (acc_wr_data),
        .acc_start   (acc_start),
        .acc_done    (acc_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [NB][NR];
    int          total = 0;
    int          bad = 0;

    function automatic logic [FLAT_W-1:0] model_flat();
        logic [FLAT_W-1:0] f;
        f = '0;
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < NR; w++)
                f[(b*NR + w)*DATA_W +: DATA_W] = mdl[b][w];
        return f;
    endfunction

    task automatic check(input string tag, input logic [FLAT_W-1:0] obs, input logic [FLAT_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] id, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] edata, input logic eerr);
        exp_t e;
        @(negedge clock);
        check("req_ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_opcode = op;
        req_id     = id;
        req_addr   = addr;
        req_data   = data;
        e.data = edata;
        e.err  = eerr;
        sb.push_back(e);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic get_resp(input int budget);
        int   n;
        exp_t e;
        n = 0;
        while (resp_valid !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("resp_seen", resp_valid, 1);
        if (resp_valid === 1'b1) begin
            check("sb_nonempty", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("resp_data", resp_data, e.data);
                check("resp_err", resp_err, e.err);
            end
            resp_ready = 1'b1;
            @(negedge clock);
            resp_ready = 1'b0;
            check("resp_drop", resp_valid, 0);
        end
    endtask

    task automatic simple(input logic [1:0] op, input logic [31:0] id, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] edata, input logic eerr);
        issue(op, id, addr, data, edata, eerr);
        check("latency1", resp_valid, 1);
        get_resp(2);
    endtask

    initial begin
        int          starts;
        logic [31:0] held;

        for (int b = 0; b < NB; b++)
            for (int w = 0; w < NR; w++)
                mdl[b][w] = '0;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_acc_start", acc_start, 0);
        check("rst_regs", acc_regs, 0);

        simple(2'd0, 0, 0, 0, 32'hDEADBEEF, 1'b0);

        simple(2'd1, 1, 2, 32'h1234, 0, 1'b0);
        mdl[1][2] = 32'h1234;
        check("word6", acc_regs[6*DATA_W +: DATA_W], 32'h1234);
        check("regs_after_wr", acc_regs, model_flat());
        simple(2'd2, 1, 2, 0, 32'h1234, 1'b0);

        simple(2'd2, 3, 0, 0, 0, 1'b1);
        simple(2'd2, 1, 4, 0, 0, 1'b1);
        simple(2'd1, 0, 32'hFFFF_0000, 32'hCAFE, 0, 1'b1);
        simple(2'd1, 4, 0, 32'hCAFE, 0, 1'b1);
        check("regs_no_bad_wr", acc_regs, model_flat());

        @(negedge clock);
        acc_wr_en = 1'b1; acc_wr_bank = 2'd3; acc_wr_addr = 2'd0; acc_wr_data = 32'hBAD;
        @(negedge clock);
        acc_wr_en = 1'b0;
        check("acc_bank_oor", acc_regs, model_flat());

        issue(2'd3, 0, 0, 0, 0, 1'b0);
        check("acc_start_hi", acc_start, 1);
        check("launch_busy", req_ready, 0);
        starts = 1;
        for (int i = 1; i <= 4; i++) begin
            acc_wr_en = (i == 2);
            acc_wr_bank = 2'd2; acc_wr_addr = 2'd0; acc_wr_data = 32'h55;
            @(negedge clock);
            if (acc_start === 1'b1) starts++;
            check("wait_busy", req_ready, 0);
            check("wait_no_resp", resp_valid, 0);
        end
        acc_wr_en = 1'b0;
        mdl[2][0] = 32'h55;
        acc_done = 1'b1;
        @(negedge clock);
        acc_done = 1'b0;
        check("launch_resp", resp_valid, 1);
        check("one_start", starts, 1);
        held = resp_data;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("hold_valid", resp_valid, 1);
            check("hold_data", resp_data, held);
            check("hold_busy", req_ready, 0);
        end
        get_resp(1);
        simple(2'd2, 2, 0, 0, 32'h55, 1'b0);

        @(negedge clock);
        req_valid = 1'b1; req_opcode = 2'd1; req_id = 0; req_addr = 0; req_data = 32'h7777;
        acc_wr_en = 1'b1; acc_wr_bank = 2'd0; acc_wr_addr = 2'd0; acc_wr_data = 32'hAAAA;
        sb.push_back('{32'h0, 1'b0});
        @(negedge clock);
        req_valid = 1'b0; acc_wr_en = 1'b0;
        mdl[0][0] = 32'h7777;
        get_resp(2);
        check("host_wins", acc_regs, model_flat());

        @(negedge clock);
        req_valid = 1'b1; req_opcode = 2'd2; req_id = 0; req_addr = 1;
        acc_wr_en = 1'b1; acc_wr_bank = 2'd0; acc_wr_addr = 2'd1; acc_wr_data = 32'h99;
        sb.push_back('{32'h0, 1'b0});
        @(negedge clock);
        req_valid = 1'b0; acc_wr_en = 1'b0;
        mdl[0][1] = 32'h99;
        get_resp(2);
        simple(2'd2, 0, 1, 0, 32'h99, 1'b0);

        issue(2'd3, 0, 0, 0, 0, 1'b0);
        repeat (2) @(negedge clock);
        check("pre_rst_busy", req_ready, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < NR; w++)
                mdl[b][w] = '0;
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_start", acc_start, 0);
        check("mid_rst_regs", acc_regs, model_flat());

        acc_done = 1'b1;
        @(negedge clock);
        acc_done = 1'b0;
        @(negedge clock);
        check("idle_done_ign", resp_valid, 0);
        check("idle_done_rdy", req_ready, 1);

        simple(2'd0, 0, 0, 0, 32'hDEADBEEF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
